// File: rtl/dir_scan_ctrl.sv
// dir_scan_ctrl: raster scan sequencer for the 16x16 direction LUT, emitting orientation-relative bins on a valid/ready stream
//   clk, rst         : clock, synchronous active-high reset
//   start, ori       : begin a scan (IDLE only) and the keypoint orientation latched with it
//   abort            : cancel any scan, back to IDLE without done
//   busy, done       : scan in progress, one-cycle pulse after the final handshake
//   rom_a, rom_spo   : LUT address {row, col} and its combinational data
//   out_*            : registered sample stream (row, col, subregion, rotated bin, last flag)
module dir_scan_ctrl #(
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  parameter int DIR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DIR_W-1:0]       ori,
  output logic                   busy,
  output logic                   done,
  output logic [ROW_W+COL_W-1:0] rom_a,
  input  logic [DIR_W-1:0]       rom_spo,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROW_W-1:0]       out_row,
  output logic [COL_W-1:0]       out_col,
  output logic [3:0]             out_sub,
  output logic [DIR_W-1:0]       out_bin,
  output logic                   out_last
);
  localparam int AW = ROW_W + COL_W;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t           r_state, w_next;
  logic [AW-1:0]    r_cnt;
  logic [DIR_W-1:0] r_ori, r_bin;
  logic [ROW_W-1:0] r_row, w_row;
  logic [COL_W-1:0] r_col, w_col;
  logic [3:0]       r_sub;
  logic             r_valid, r_last, r_done;
  logic             w_load, w_hs, w_end;
  assign w_row = r_cnt[AW-1:COL_W];
  assign w_col = r_cnt[COL_W-1:0];
  assign w_hs  = r_valid && out_ready;
  assign w_end = &r_cnt;
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    if (abort)
      w_next = IDLE;
    else if (r_state == IDLE && start)
      w_next = RUN;
    else if (r_state == RUN) begin
      w_load = !r_valid || out_ready;
      w_next = (w_load && w_end) ? FLUSH : RUN;
    end else if (r_state == FLUSH && w_hs)
      w_next = IDLE;
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ori   <= '0;
      r_valid <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_sub   <= '0;
      r_bin   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= !abort && r_state == FLUSH && w_hs;
      if (abort) begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == IDLE && start) begin
        r_ori <= ori;
        r_cnt <= '0;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_row   <= w_row;
        r_col   <= w_col;
        r_sub   <= {w_row[ROW_W-1 -: 2], w_col[COL_W-1 -: 2]};
        r_bin   <= rom_spo - r_ori;
        r_last  <= w_end;
        r_cnt   <= r_cnt + AW'(1);
      end else if (r_state == FLUSH && w_hs)
        r_valid <= 1'b0;
    end
  end
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign rom_a     = r_cnt;
  assign out_valid = r_valid;
  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_sub   = r_sub;
  assign out_bin   = r_bin;
  assign out_last  = r_last;
endmodule

// File: tb/tb_dir_scan_ctrl.sv
// tb_dir_scan_ctrl: randomized self-checking bench for dir_scan_ctrl against an arithmetic scan model
module tb_dir_scan_ctrl;
  logic       clk = 0, rst = 1, start = 0, abort = 0, out_ready = 0;
  logic [4:0] ori = 0, rom_spo, out_bin;
  logic       busy, done, out_valid, out_last;
  logic [7:0] rom_a;
  logic [3:0] out_row, out_col, out_sub;
  logic [4:0] lut [256];
  int n_cmp = 0, n_err = 0, edge_n = 0, rdy_pct = 100, stall_err = 0, e0 = 0;
  bit mon_en = 0, prev_stall = 0;
  logic [17:0] prev_rec;
  logic [17:0] q_rec[$];
  int q_cyc[$], d_cyc[$];
  wire [17:0] w_rec = {out_row, out_col, out_sub, out_bin, out_last};
  assign rom_spo = lut[rom_a];
  always #5 clk = ~clk;
  dir_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ori(ori),
    .busy(busy), .done(done), .rom_a(rom_a), .rom_spo(rom_spo),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_col(out_col), .out_sub(out_sub), .out_bin(out_bin), .out_last(out_last)
  );
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(posedge clk) begin
    #1;
    out_ready = (int'($urandom_range(99)) < rdy_pct);
  end
  // each record is stamped with the edge count at presentation; the handshake happens on the following edge
  always @(negedge clk) if (mon_en) begin
    if (prev_stall && (out_valid !== 1'b1 || w_rec !== prev_rec)) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_rec = w_rec;
    if (out_valid && out_ready) begin
      q_rec.push_back(w_rec);
      q_cyc.push_back(edge_n);
    end
    if (done) d_cyc.push_back(edge_n);
  end
  function automatic logic [17:0] exp_rec(input int k, input int o);
    int r = k / 16, c = k % 16;
    return {4'(r), 4'(c), 4'((r / 4) * 4 + c / 4), 5'((int'(lut[k]) - o + 32) % 32), 1'(k == 255)};
  endfunction
  task automatic clr();
    q_rec.delete(); q_cyc.delete(); d_cyc.delete();
    stall_err = 0; prev_stall = 0;
  endtask
  task automatic fill_lut();
    for (int i = 0; i < 256; i++) lut[i] = 5'($urandom);
    lut[0] = 5'h1d; lut[255] = 5'h03; lut[3] = 5'h00;
  endtask
  task automatic start_scan(input logic [4:0] o);
    @(posedge clk); #1 start = 1; ori = o;
    @(posedge clk); #1 start = 0; ori = 5'($urandom);
    e0 = edge_n;
  endtask
  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (done === 1'b1);
    end
    #1;
  endtask
  task automatic wait_samples(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (q_rec.size() >= n);
    end
  endtask
  task automatic test_reset();
    bit ok;
    logic [4:0] o = 5'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    n_cmp++;
    if ({busy, done, out_valid, out_last, out_row, out_col, out_sub, out_bin, rom_a} !== '0) begin
      n_err++; $display("FAIL reset_por got=%h exp=0", {busy, done, out_valid, out_last, out_row, out_col, out_sub, out_bin, rom_a});
    end
    fill_lut(); clr(); mon_en = 1; rdy_pct = 100;
    start_scan(o);
    wait_samples(60, ok);
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n_cmp++;
    if ({busy, done, out_valid, out_last, out_row, out_col, out_sub, out_bin, rom_a} !== '0) begin
      n_err++; $display("FAIL reset_mid got=%h exp=0", {busy, done, out_valid, out_last, out_row, out_col, out_sub, out_bin, rom_a});
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (d_cyc.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_nodone dones=%0d busy=%b exp 0/0", d_cyc.size(), busy);
    end
    clr(); o = 5'($urandom);
    start_scan(o);
    wait_done(ok);
    n_cmp++;
    if (!ok || q_rec.size() != 256 || q_rec[0] !== exp_rec(0, o)) begin
      n_err++; $display("FAIL reset_rescan ok=%b n=%0d first=%h exp 1/256/%h", ok, q_rec.size(), q_rec.size() ? q_rec[0] : 18'h0, exp_rec(0, o));
    end
  endtask
  task automatic test_basic();
    bit ok;
    clr(); fill_lut(); rdy_pct = 100;
    start_scan(5'd0);
    n_cmp++;
    if (busy !== 1'b1 || rom_a !== 8'd0) begin
      n_err++; $display("FAIL basic_busy busy=%b rom_a=%0d exp 1/0", busy, rom_a);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || busy !== 1'b0 || q_rec.size() != 256) begin
      n_err++; $display("FAIL basic_count ok=%b busy=%b n=%0d exp 1/0/256", ok, busy, q_rec.size());
    end
    for (int k = 0; k < 256 && k < q_rec.size(); k++) begin
      n_cmp++;
      if (q_rec[k] !== exp_rec(k, 0)) begin
        n_err++; $display("FAIL basic_sample k=%0d got=%h exp=%h", k, q_rec[k], exp_rec(k, 0));
      end
    end
    if (q_rec.size() == 256) begin
      n_cmp++;
      if (q_rec[0][5:1] !== 5'h1d || q_rec[255][5:0] !== {5'h03, 1'b1}) begin
        n_err++; $display("FAIL basic_ends first_bin=%h last=%h exp 1d/07", q_rec[0][5:1], q_rec[255][5:0]);
      end
      n_cmp++;
      if (q_cyc[0] != e0 + 1 || q_cyc[255] != e0 + 256) begin
        n_err++; $display("FAIL basic_timing first=%0d last=%0d exp %0d/%0d", q_cyc[0] - e0, q_cyc[255] - e0, 1, 256);
      end
    end
    n_cmp++;
    if (d_cyc.size() != 1 || d_cyc[0] != e0 + 257) begin
      n_err++; $display("FAIL basic_done n=%0d at=%0d exp 1/257", d_cyc.size(), d_cyc.size() ? d_cyc[0] - e0 : -1);
    end
  endtask
  task automatic test_wrap();
    bit ok;
    int o_t[3] = '{30, 5, 31};
    int k_t[3] = '{0, 255, 3};
    int b_t[3] = '{31, 30, 1};
    rdy_pct = 100;
    for (int t = 0; t < 3; t++) begin
      clr(); fill_lut();
      start_scan(5'(o_t[t]));
      wait_done(ok);
      n_cmp++;
      if (!ok || q_rec.size() != 256 || int'(q_rec[k_t[t]][5:1]) != b_t[t]) begin
        n_err++; $display("FAIL wrap_%0d ok=%b n=%0d bin=%h exp=%h", t, ok, q_rec.size(), q_rec.size() == 256 ? q_rec[k_t[t]][5:1] : 5'h0, b_t[t]);
      end
    end
  endtask
  task automatic test_backpressure();
    bit ok;
    logic [4:0] o = 5'($urandom);
    clr(); fill_lut(); rdy_pct = 50;
    start_scan(o);
    wait_done(ok);
    rdy_pct = 100;
    n_cmp++;
    if (!ok || q_rec.size() != 256) begin
      n_err++; $display("FAIL bp_count ok=%b n=%0d exp 1/256", ok, q_rec.size());
    end
    for (int k = 0; k < 256 && k < q_rec.size(); k++) begin
      n_cmp++;
      if (q_rec[k] !== exp_rec(k, o)) begin
        n_err++; $display("FAIL bp_sample k=%0d got=%h exp=%h", k, q_rec[k], exp_rec(k, o));
      end
    end
    n_cmp++;
    if (stall_err != 0) begin
      n_err++; $display("FAIL bp_stable unstable=%0d exp 0", stall_err);
    end
    n_cmp++;
    if (d_cyc.size() != 1 || q_rec.size() != 256 || d_cyc[0] != q_cyc[255] + 1) begin
      n_err++; $display("FAIL bp_done n=%0d at=%0d exp 1/%0d", d_cyc.size(), d_cyc.size() ? d_cyc[0] : -1, q_cyc.size() ? q_cyc[q_cyc.size() - 1] + 1 : -1);
    end
  endtask
  task automatic test_ignored_start();
    bit ok;
    clr(); fill_lut(); rdy_pct = 100;
    start_scan(5'd0);
    wait_samples(100, ok);
    @(posedge clk); #1 start = 1; ori = 5'd7;
    @(posedge clk); #1 start = 0;
    wait_done(ok);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 256 && k < q_rec.size(); k++) begin
      n_cmp++;
      if (q_rec[k] !== exp_rec(k, 0)) begin
        n_err++; $display("FAIL ign_sample k=%0d got=%h exp=%h", k, q_rec[k], exp_rec(k, 0));
      end
    end
    n_cmp++;
    if (!ok || d_cyc.size() != 1 || q_rec.size() != 256 || busy !== 1'b0) begin
      n_err++; $display("FAIL ign_once ok=%b dones=%0d n=%0d busy=%b exp 1/1/256/0", ok, d_cyc.size(), q_rec.size(), busy);
    end
  endtask
  task automatic test_abort();
    bit ok;
    logic [4:0] o = 5'($urandom);
    clr(); fill_lut(); rdy_pct = 100;
    start_scan(o);
    wait_samples(40, ok);
    n_cmp++;
    if (!ok || out_valid !== 1'b1) begin
      n_err++; $display("FAIL abort_pre ok=%b valid=%b exp 1/1", ok, out_valid);
    end
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_post valid=%b busy=%b exp 0/0", out_valid, busy);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (d_cyc.size() != 0) begin
      n_err++; $display("FAIL abort_nodone dones=%0d exp 0", d_cyc.size());
    end
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL abort_wins busy=%b exp 0", busy);
    end
    clr(); o = 5'($urandom);
    start_scan(o);
    wait_done(ok);
    n_cmp++;
    if (!ok || q_rec.size() != 256 || q_rec[0] !== exp_rec(0, o) || q_rec[255] !== exp_rec(255, o)) begin
      n_err++; $display("FAIL abort_restart ok=%b n=%0d first=%h exp=%h", ok, q_rec.size(), q_rec.size() ? q_rec[0] : 18'h0, exp_rec(0, o));
    end
  endtask
  task automatic test_back_to_back();
    bit ok = 0;
    int e1;
    logic [4:0] o1 = 5'($urandom), o2 = 5'($urandom);
    clr(); fill_lut(); rdy_pct = 100;
    start_scan(o1);
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (done === 1'b1);
    end
    start = 1; ori = o2;
    @(posedge clk); #1 start = 0;
    e1 = edge_n;
    n_cmp++;
    if (!ok || busy !== 1'b1 || rom_a !== 8'd0) begin
      n_err++; $display("FAIL b2b_accept ok=%b busy=%b rom_a=%0d exp 1/1/0", ok, busy, rom_a);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || q_rec.size() != 512 || d_cyc.size() != 2) begin
      n_err++; $display("FAIL b2b_count ok=%b n=%0d dones=%0d exp 1/512/2", ok, q_rec.size(), d_cyc.size());
    end
    if (q_rec.size() == 512) begin
      n_cmp++;
      if (q_rec[255] !== exp_rec(255, o1) || q_rec[256] !== exp_rec(0, o2) || q_rec[511] !== exp_rec(255, o2) || q_cyc[256] != e1 + 1) begin
        n_err++; $display("FAIL b2b_seam a=%h b=%h c=%h at=%0d exp %h/%h/%h/1", q_rec[255], q_rec[256], q_rec[511], q_cyc[256] - e1, exp_rec(255, o1), exp_rec(0, o2), exp_rec(255, o2));
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 5'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
